// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode/funct constants and the issue bundle shared by issue and ALU
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        arith_mode;
        logic        logic_alt;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        wb;
        logic        branch;
        logic        illegal;
    } issue_bundle_t;

endpackage

// File: rtl/issue_stage_regfile.sv
// rtl/issue_stage_regfile.sv - 32x32 integer register file, two async reads, one write, x0 hardwired
module issue_stage_regfile #(
    parameter int RESET_REGS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    output logic [31:0] rdata_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [31:0];

    // Optional clear on reset, otherwise write port; x0 is never written
    always_ff @(posedge clk) begin
        if (rst && (RESET_REGS != 0)) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/issue_stage.sv
// rtl/issue_stage.sv - RV32I decode/issue with scoreboard, writeback bypass and registered ALU bundle
module issue_stage
    import rv32_pkg::*;
#(
    parameter int RESET_REGS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ra,
    output logic [31:0] out_rb,
    output logic [31:0] out_imm,
    output logic [31:0] out_pc,
    output logic        out_arith_mode,
    output logic        out_logic_alt,
    output logic [2:0]  out_funct3,
    output logic [4:0]  out_rd,
    output logic        out_wb,
    output logic        out_branch,
    output logic        out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] imm_b;
    logic [31:0] shamt;

    assign opcode = in_inst[6:0];
    assign f3     = in_inst[14:12];
    assign f7     = in_inst[31:25];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign rd     = in_inst[11:7];
    assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_u  = {in_inst[31:12], 12'd0};
    assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign shamt  = {27'd0, in_inst[24:20]};

    logic [31:0] rf_a;
    logic [31:0] rf_b;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    issue_stage_regfile #(
        .RESET_REGS (RESET_REGS)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs1),
        .rdata_a (rf_a),
        .raddr_b (rs2),
        .rdata_b (rf_b),
        .we      (wb_en),
        .waddr   (wb_rd),
        .wdata   (wb_data)
    );

    // A result arriving this cycle is forwarded so the dependent instruction issues without a bubble
    assign rs1_val = (wb_en && (wb_rd == rs1) && (rs1 != 5'd0)) ? wb_data : rf_a;
    assign rs2_val = (wb_en && (wb_rd == rs2) && (rs2 != 5'd0)) ? wb_data : rf_b;

    issue_bundle_t dec;
    logic          rs1_used;
    logic          rs2_used;
    logic          illegal;

    // Decode the fetched instruction into the ALU bundle and its register usage
    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.funct3 = f3;
        dec.rd     = rd;
        rs1_used   = 1'b0;
        rs2_used   = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                dec.ra         = rs1_val;
                dec.rb         = rs2_val;
                dec.arith_mode = (f3 == F3_ADD_SUB) ? in_inst[30] : ((f3 == F3_SLT) || (f3 == F3_SLTU));
                dec.logic_alt  = (f3 == F3_SRL_SRA) && in_inst[30];
                if (!((f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))))) begin
                    illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                rs1_used       = 1'b1;
                dec.ra         = rs1_val;
                dec.rb         = ((f3 == F3_SLL) || (f3 == F3_SRL_SRA)) ? shamt : imm_i;
                dec.imm        = dec.rb;
                dec.arith_mode = (f3 == F3_SLT) || (f3 == F3_SLTU);
                dec.logic_alt  = (f3 == F3_SRL_SRA) && in_inst[30];
                if (((f3 == F3_SLL) && (f7 != F7_BASE)) ||
                    ((f3 == F3_SRL_SRA) && (f7 != F7_BASE) && (f7 != F7_ALT))) begin
                    illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.rb     = imm_u;
                dec.imm    = imm_u;
                dec.funct3 = F3_ADD_SUB;
            end
            OPC_AUIPC: begin
                dec.ra     = in_pc;
                dec.rb     = imm_u;
                dec.imm    = imm_u;
                dec.funct3 = F3_ADD_SUB;
            end
            OPC_BRANCH: begin
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                dec.ra         = rs1_val;
                dec.rb         = rs2_val;
                dec.imm        = imm_b;
                dec.arith_mode = 1'b1;
                dec.branch     = 1'b1;
                dec.rd         = 5'd0;
                if ((f3 == F3_SLT) || (f3 == F3_SLTU)) begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
        dec.illegal = illegal;
        dec.wb      = !illegal && !dec.branch && (dec.rd != 5'd0);
    end

    logic [31:0] pending;
    logic [31:0] pend_eff;
    logic [31:0] clr_mask;
    logic [31:0] set_mask;
    logic        hazard;
    logic        accept;

    // The writeback of this cycle releases its register before the hazard check
    assign clr_mask = wb_en ? (32'd1 << wb_rd) : 32'd0;
    assign pend_eff = pending & ~clr_mask;
    assign hazard   = (rs1_used && pend_eff[rs1]) ||
                      (rs2_used && pend_eff[rs2]) ||
                      (dec.wb && pend_eff[dec.rd]);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign set_mask = (accept && dec.wb) ? (32'd1 << dec.rd) : 32'd0;

    // Scoreboard: a new claim on rd overrides a same-cycle release of it
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 32'd0;
        end else begin
            pending <= pend_eff | set_mask;
        end
    end

    issue_bundle_t out_q;

    // Output register: load on accept, hold while stalled, drop valid once consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_ra         = out_q.ra;
    assign out_rb         = out_q.rb;
    assign out_imm        = out_q.imm;
    assign out_pc         = out_q.pc;
    assign out_arith_mode = out_q.arith_mode;
    assign out_logic_alt  = out_q.logic_alt;
    assign out_funct3     = out_q.funct3;
    assign out_rd         = out_q.rd;
    assign out_wb         = out_q.wb;
    assign out_branch     = out_q.branch;
    assign out_illegal    = out_q.illegal;

endmodule

// File: tb/tb_issue_stage.sv
// tb/tb_issue_stage.sv - table-driven and directed checks for issue_stage
module tb_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ra;
    logic [31:0] out_rb;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_arith_mode;
    logic        out_logic_alt;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic        out_wb;
    logic        out_branch;
    logic        out_illegal;

    issue_stage #(.RESET_REGS(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ra         (out_ra),
        .out_rb         (out_rb),
        .out_imm        (out_imm),
        .out_pc         (out_pc),
        .out_arith_mode (out_arith_mode),
        .out_logic_alt  (out_logic_alt),
        .out_funct3     (out_funct3),
        .out_rd         (out_rd),
        .out_wb         (out_wb),
        .out_branch     (out_branch),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic        am;
        logic        la;
        logic [4:0]  rd;
        logic        wb;
        logic        br;
        logic        il;
        logic        chk_data;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] ra,
                           input logic [31:0] rb, input logic [31:0] imm, input logic [2:0] f3,
                           input logic am, input logic la, input logic [4:0] rd, input logic wb,
                           input logic br, input logic il, input logic chk_data);
        vec_t v;
        v.inst = inst; v.pc = pc; v.ra = ra; v.rb = rb; v.imm = imm; v.f3 = f3;
        v.am = am; v.la = la; v.rd = rd; v.wb = wb; v.br = br; v.il = il; v.chk_data = chk_data;
        vq.push_back(v);
    endtask

    // Wait (bounded) for in_ready while an instruction is presented
    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, in_ready, 1'b1);
    endtask

    task automatic writeback(input logic [4:0] rd, input logic [31:0] data);
        wb_en = 1'b1; wb_rd = rd; wb_data = data;
        @(negedge clk);
        wb_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;

        // x1 = 0x80000000, x2 = 7 once the table runs
        add_vec(32'h00500293, 32'h0,   32'h0,        32'h5,        32'h5,        3'd0, 0, 0, 5'd5, 1, 0, 0, 1);
        add_vec(32'h00208333, 32'h4,   32'h80000000, 32'h7,        32'h0,        3'd0, 0, 0, 5'd6, 1, 0, 0, 1);
        add_vec(32'h40208333, 32'h8,   32'h80000000, 32'h7,        32'h0,        3'd0, 1, 0, 5'd6, 1, 0, 0, 1);
        add_vec(32'h4030D293, 32'hC,   32'h80000000, 32'h3,        32'h3,        3'd5, 0, 1, 5'd5, 1, 0, 0, 1);
        add_vec(32'h0020A3B3, 32'h10,  32'h80000000, 32'h7,        32'h0,        3'd2, 1, 0, 5'd7, 1, 0, 0, 1);
        add_vec(32'h4020D3B3, 32'h14,  32'h80000000, 32'h7,        32'h0,        3'd5, 0, 1, 5'd7, 1, 0, 0, 1);
        add_vec(32'h00208463, 32'h18,  32'h80000000, 32'h7,        32'h8,        3'd0, 1, 0, 5'd0, 0, 1, 0, 1);
        add_vec(32'hFE20CEE3, 32'h1C,  32'h80000000, 32'h7,        32'hFFFFFFFC, 3'd4, 1, 0, 5'd0, 0, 1, 0, 1);
        add_vec(32'h00001297, 32'h100, 32'h100,      32'h1000,     32'h1000,     3'd0, 0, 0, 5'd5, 1, 0, 0, 1);
        add_vec(32'hFFF0B293, 32'h20,  32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 1, 0, 5'd5, 1, 0, 0, 1);
        add_vec(32'hFF00F293, 32'h24,  32'h80000000, 32'hFFFFFFF0, 32'hFFFFFFF0, 3'd7, 0, 0, 5'd5, 1, 0, 0, 1);
        add_vec(32'h00208033, 32'h28,  32'h80000000, 32'h7,        32'h0,        3'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        add_vec(32'h0000007F, 32'h2C,  32'h0,        32'h0,        32'h0,        3'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        add_vec(32'h02208333, 32'h30,  32'h0,        32'h0,        32'h0,        3'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        add_vec(32'h40109293, 32'h34,  32'h0,        32'h0,        32'h0,        3'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        add_vec(32'h0020A463, 32'h38,  32'h0,        32'h0,        32'h0,        3'd0, 0, 0, 5'd0, 0, 1, 1, 0);

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_ra", out_ra, 32'h0);
        chk("reset out_rb", out_rb, 32'h0);
        chk("reset out_imm", out_imm, 32'h0);
        chk("reset in_ready", in_ready, 1'b1);

        // addi x1,x0,5 then dependent add x3,x1,x2 released by a bypassed writeback
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0;
        @(negedge clk);
        in_inst = 32'h002081B3;
        chk("addi out_valid", out_valid, 1'b1);
        chk("addi ra", out_ra, 32'h0);
        chk("addi rb", out_rb, 32'h5);
        chk("addi funct3", out_funct3, 3'd0);
        chk("addi arith_mode", out_arith_mode, 1'b0);
        chk("addi rd", out_rd, 5'd1);
        chk("addi wb", out_wb, 1'b1);
        #1;
        chk("raw hazard in_ready", in_ready, 1'b0);
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
        #1;
        chk("wb release in_ready", in_ready, 1'b1);
        @(negedge clk);
        wb_en = 1'b0; in_valid = 1'b0;
        chk("bypass out_valid", out_valid, 1'b1);
        chk("bypass ra", out_ra, 32'h5);
        chk("bypass rb", out_rb, 32'h0);
        chk("bypass rd", out_rd, 5'd3);
        writeback(5'd3, 32'h0);

        writeback(5'd1, 32'h80000000);
        writeback(5'd2, 32'h7);

        foreach (vq[i]) begin
            in_valid = 1'b1; in_inst = vq[i].inst; in_pc = vq[i].pc;
            wait_ready($sformatf("v%0d in_ready", i));
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), out_valid, 1'b1);
            chk($sformatf("v%0d illegal", i), out_illegal, vq[i].il);
            chk($sformatf("v%0d wb", i), out_wb, vq[i].wb);
            if (vq[i].chk_data) begin
                chk($sformatf("v%0d ra", i), out_ra, vq[i].ra);
                chk($sformatf("v%0d rb", i), out_rb, vq[i].rb);
                chk($sformatf("v%0d imm", i), out_imm, vq[i].imm);
                chk($sformatf("v%0d pc", i), out_pc, vq[i].pc);
                chk($sformatf("v%0d funct3", i), out_funct3, vq[i].f3);
                chk($sformatf("v%0d arith_mode", i), out_arith_mode, vq[i].am);
                chk($sformatf("v%0d logic_alt", i), out_logic_alt, vq[i].la);
                chk($sformatf("v%0d rd", i), out_rd, vq[i].rd);
                chk($sformatf("v%0d branch", i), out_branch, vq[i].br);
            end
            if (vq[i].wb) begin
                writeback(vq[i].rd, 32'h0);
            end
        end

        // lui x1 held under backpressure for three cycles
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h123450B7; in_pc = 32'h40;
        #1;
        chk("lui in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_inst = 32'h00100293;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d out_valid", c), out_valid, 1'b1);
            chk($sformatf("stall%0d rb", c), out_rb, 32'h12345000);
            chk($sformatf("stall%0d ra", c), out_ra, 32'h0);
            chk($sformatf("stall%0d rd", c), out_rd, 5'd1);
            chk($sformatf("stall%0d pc", c), out_pc, 32'h40);
            chk($sformatf("stall%0d in_ready", c), in_ready, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1; in_inst = 32'h0000007F;
        #1;
        chk("illegal in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("illegal out_valid", out_valid, 1'b1);
        chk("illegal flag", out_illegal, 1'b1);
        chk("illegal wb", out_wb, 1'b0);

        // Reset with a held bundle and x1 still pending
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst out_illegal", out_illegal, 1'b0);
        chk("rst out_rb", out_rb, 32'h0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_inst = 32'h00208333; in_pc = 32'h0;
        #1;
        chk("rst pending cleared", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst post out_valid", out_valid, 1'b1);
        chk("rst regs x1", out_ra, 32'h0);
        chk("rst regs x2", out_rb, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
Decode/issue stage that produces the operand and control bundle consumed by the ALU: ra, rb, arith_mode, logic_alt, funct3.
- Decodes RV32I OP, OP-IMM, LUI, AUIPC and BRANCH instructions.
- Owns the integer register file and a pending-write scoreboard.
- Takes the result back on a writeback port.
- Sits between fetch (valid/ready) and the execute stage (valid/ready), with one registered output stage.

Parameters:
RESET_REGS, 1, 1 = x1..x31 cleared by rst; 0 = register file contents not reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  fetch holds a valid instruction.
in_ready  output  1  stage accepts the instruction this cycle.
in_inst  input  32  instruction word.
in_pc  input  32  PC of in_inst.
wb_en  input  1  writeback strobe.
wb_rd  input  5  writeback destination register.
wb_data  input  32  writeback value.
out_valid  output  1  output bundle valid.
out_ready  input  1  execute stage consumes the bundle.
out_ra  output  32  ALU operand A.
out_rb  output  32  ALU operand B.
out_imm  output  32  sign-extended immediate; branch offset for BRANCH.
out_pc  output  32  PC of the issued instruction.
out_arith_mode  output  1  1 = subtract/compare, 0 = add.
out_logic_alt  output  1  inst[30] for shifts (SRA/SRAI); 0 otherwise.
out_funct3  output  3  funct3; forced to 000 for LUI/AUIPC.
out_rd  output  5  destination register.
out_wb  output  1  instruction writes rd (rd != 0, legal, not BRANCH).
out_branch  output  1  BRANCH instruction.
out_illegal  output  1  undecodable instruction.

Behaviour:
- Handshake and latency:
  - Accept = in_valid && in_ready.
  - in_ready = (!out_valid || out_ready) && !hazard; combinational, does not depend on in_valid.
  - Latency is 1 cycle from accept to out_valid.
  - Output register holds every field stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new accept occurs in the same cycle.
- Decode:
  - OP: rb = rs2; arith_mode = inst[30] for funct3 000; arith_mode = 1 for 010/011 (SLT/SLTU); logic_alt = inst[30] for 101.
  - OP funct7 other than 0000000, or other than 0100000 with funct3 in {000, 101} → illegal.
  - OP-IMM: rb = I-immediate; arith_mode = 0 for 000, 1 for 010/011.
  - SLLI with funct7 != 0, or SRLI/SRAI with funct7 outside {0000000, 0100000} → illegal.
  - LUI: ra = 0, rb = U-immediate, funct3 = 000, arith_mode = 0.
  - AUIPC: ra = pc, rb = U-immediate, funct3 = 000, arith_mode = 0.
  - BRANCH: ra = rs1, rb = rs2, arith_mode = 1, imm = B-immediate; funct3 010 or 011 → illegal.
  - Any other opcode → illegal.
  - Illegal instructions are still issued: out_illegal = 1, out_wb = 0, no scoreboard set.
- Register file: 32x32, two asynchronous read ports, one write port.
  - x0 reads 0; writes to x0 are ignored.
  - Write occurs on wb_en.
- Bypass: if wb_en && wb_rd == rs && rs != 0, the operand read takes wb_data in the same cycle.
- Scoreboard: pending[31:1].
  - Set on accept of a legal instruction with out_wb = 1.
  - Cleared on wb_en for wb_rd.
  - Same-cycle set and clear of the same rd → set wins.
- Hazard is evaluated after applying this cycle's wb clear:
  - hazard = (pending[rs1] && rs1 used) || (pending[rs2] && rs2 used) || (pending[rd] && writes rd).
  - rs2 is used only by OP and BRANCH; rs1 is not used by LUI/AUIPC.
  - Only decoded fields of legal instructions count.
- Reset:
  - out_valid = 0; all out_* data fields = 0; pending = 0.
  - Registers cleared if RESET_REGS = 1.
  - Reset mid-stall drops the held bundle; the in-flight instruction is lost. Fetch is responsible for replay.
- wb_en for a non-pending register: write occurs; no error.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OP, OP_IMM, LUI, AUIPC, BRANCH);
  - funct3 constants;
  - the issue-bundle struct (ra, rb, imm, pc, arith_mode, logic_alt, funct3, rd, wb, branch, illegal).
- The ALU uses the same funct3 constants.
- One sub-module: regfile (2R1W, x0 hardwired, optional reset). Decode, bypass and scoreboard stay in issue_stage.

Test Plan:
- Reset; send addi x1,x0,5 (0x00500093), out_ready = 1 → next cycle out_valid = 1, ra = 0, rb = 5, funct3 = 000, arith_mode = 0, rd = 1, out_wb = 1; pending[1] = 1.
- Send add x3,x1,x2 (0x002081B3) while pending[1] = 1 → in_ready = 0. Then pulse wb_en, wb_rd = 1, wb_data = 5 → in_ready = 1 the same cycle and out_ra = 5 (bypass).
- Send srai x5,x1,3 (0x4030D293) with x1 = 0x80000000 → rb = 3, funct3 = 101, logic_alt = 1. Send sub x3,x1,x2 (0x402081B3) → arith_mode = 1.
- Send beq x1,x2,+8 (0x00208463) → out_branch = 1, arith_mode = 1, imm = 8, out_wb = 0; no scoreboard change.
- Send lui x1,0x12345 (0x123450B7) with out_ready = 0 for 3 cycles → bundle stable, rb = 0x12345000, in_ready = 0. Send opcode 0x7F → out_illegal = 1, out_wb = 0.
- Assert rst while out_valid = 1 and pending[1] = 1 → next cycle out_valid = 0, pending = 0, in_ready = 1.
